// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner IDs are stored in the outstanding-read FIFO and drive the request mux.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } dmem_req_t;

  // funct3 load/store size codes; the arbiter passes them through untouched
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic dmem_req_t pack_req(input logic        we,
                                         input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         input logic [2:0]  size);
    dmem_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.size  = size;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_chk.sv
// Protocol checker for the arbiter's requester interfaces.
// A requester must keep its request raised until it is granted.
module dmem_arb_chk (
  input logic clk,
  input logic rst,
  input logic c_req,
  input logic c_gnt,
  input logic a_req,
  input logic a_gnt
);

  core_req_held: assert property (@(posedge clk) disable iff (rst)
    (c_req && !c_gnt) |=> c_req);

  aux_req_held: assert property (@(posedge clk) disable iff (rst)
    (a_req && !a_gnt) |=> a_req);

endmodule

// File: rtl/dmem_arb_id_fifo.sv
// Owner-ID FIFO tracking outstanding reads in request order.
// Pointers wrap modulo MAX_OUT so any depth >= 1 works.
module dmem_arb_id_fifo
  import dmem_arb_pkg::*;
#(
  parameter int MAX_OUT = 2,
  localparam int CW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  owner_e        push_id,
  input  logic          pop,
  output owner_e        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  owner_e        slot_r [MAX_OUT];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_r == CW'(MAX_OUT));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head      = slot_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < MAX_OUT; i++) slot_r[i] <= OWN_NONE;
    end else begin
      if (push_ok_s) begin
        slot_r[wr_ptr_r] <= push_id;
        wr_ptr_r         <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core MEM stage (fixed priority) vs. auxiliary master.
// Aux gets one priority grant after STARVE_LIMIT waiting cycles; the chosen owner
// is frozen while memory back-pressures. Read responses return in order and are
// steered to their owner via an ID FIFO.
// Optional build macro DMEM_ARB_PERF_EN adds perf_conflict / perf_aux_gnt counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_size,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [2:0]  a_size,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_unexp
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_aux_gnt
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  owner_e        pick_s;
  owner_e        owner_s;
  owner_e        lock_owner_r;
  logic          lock_r;
  logic [SW-1:0] starve_cnt_r;
  logic          starve_hit_s;
  logic          err_unexp_r;
  logic [CW-1:0] core_pend_r;
  logic          mem_req_s;
  dmem_req_t     mux_req_s;

  owner_e        head_s;
  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  owner_e        push_id_s;
  logic          pop_s;
  logic          core_load_gnt_s;
  logic          core_rsp_s;

  assign starve_hit_s = (starve_cnt_r >= SW'(STARVE_LIMIT));

  // Owner choice: frozen while locked, else aux on starvation or idle core
  always_comb begin
    pick_s  = OWN_NONE;
    owner_s = OWN_NONE;
    if (a_req && (!c_req || starve_hit_s)) begin
      pick_s = OWN_AUX;
    end else if (c_req) begin
      pick_s = OWN_CORE;
    end else begin
      pick_s = OWN_NONE;
    end
    if (lock_r) begin
      owner_s = lock_owner_r;
    end else begin
      owner_s = pick_s;
    end
  end

  // Request mux towards memory; idle bus when nobody owns it
  always_comb begin
    mux_req_s = '0;
    case (owner_s)
      OWN_CORE: mux_req_s = pack_req(c_we, c_addr, c_wdata, c_size);
      OWN_AUX:  mux_req_s = pack_req(a_we, a_addr, a_wdata, a_size);
      default:  mux_req_s = '0;
    endcase
  end

  // Full is judged on the registered count, so a same-cycle pop does not unblock
  assign mem_req_s = (owner_s != OWN_NONE) & ~full_s;
  assign mem_req   = mem_req_s;
  assign mem_we    = mux_req_s.we;
  assign mem_addr  = mux_req_s.addr;
  assign mem_wdata = mux_req_s.wdata;
  assign mem_size  = mux_req_s.size;

  assign c_gnt = mem_req_s & mem_gnt & (owner_s == OWN_CORE);
  assign a_gnt = mem_req_s & mem_gnt & (owner_s == OWN_AUX);

  // Only loads expect a response, so only loads enter the ID FIFO
  assign core_load_gnt_s = c_gnt & ~c_we;
  assign push_s          = core_load_gnt_s | (a_gnt & ~a_we);
  assign push_id_s       = a_gnt ? OWN_AUX : OWN_CORE;
  assign pop_s           = mem_rvalid & ~empty_s;
  assign core_rsp_s      = pop_s & (head_s == OWN_CORE);

  dmem_arb_id_fifo #(
    .MAX_OUT (MAX_OUT)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .push_id (push_id_s),
    .pop     (pop_s),
    .head    (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign c_rvalid  = core_rsp_s;
  assign a_rvalid  = pop_s & (head_s == OWN_AUX);
  assign c_rdata   = mem_rdata;
  assign a_rdata   = mem_rdata;
  assign c_stall   = (c_req & ~c_gnt) | (core_pend_r != '0);
  assign err_unexp = err_unexp_r;

  // Hold the owner across a back-pressured request until memory accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r       <= 1'b0;
      lock_owner_r <= OWN_NONE;
    end else if (mem_req_s && !mem_gnt) begin
      lock_r       <= 1'b1;
      lock_owner_r <= owner_s;
    end else begin
      lock_r       <= 1'b0;
      lock_owner_r <= OWN_NONE;
    end
  end

  // Count consecutive aux wait cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (a_req && !a_gnt) begin
      if (!starve_hit_s) begin
        starve_cnt_r <= starve_cnt_r + SW'(1);
      end
    end else begin
      starve_cnt_r <= '0;
    end
  end

  // Number of core loads still awaiting data; drives the core stall
  always_ff @(posedge clk) begin
    if (rst) begin
      core_pend_r <= '0;
    end else begin
      case ({core_load_gnt_s, core_rsp_s})
        2'b10:   core_pend_r <= core_pend_r + CW'(1);
        2'b01:   core_pend_r <= core_pend_r - CW'(1);
        default: core_pend_r <= core_pend_r;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unexp_r <= 1'b0;
    end else if (mem_rvalid && empty_s) begin
      err_unexp_r <= 1'b1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflict_r;
  logic [31:0] perf_aux_gnt_r;

  // Wrapping event counters: contention cycles and aux grants
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_r <= 32'd0;
      perf_aux_gnt_r  <= 32'd0;
    end else begin
      if (c_req && a_req) perf_conflict_r <= perf_conflict_r + 32'd1;
      if (a_gnt)          perf_aux_gnt_r  <= perf_aux_gnt_r + 32'd1;
    end
  end

  assign perf_conflict = perf_conflict_r;
  assign perf_aux_gnt  = perf_aux_gnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants and
// read responses into queues; a negedge monitor pops and compares them.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_gnt, c_rvalid, c_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [2:0]  c_size;
  logic        a_req, a_we, a_gnt, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [2:0]  a_size;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;
  logic        err_unexp;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_aux_gnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        aux;
    logic [31:0] val;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];

  dmem_arbiter #(.MAX_OUT(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .err_unexp(err_unexp)
`ifdef DMEM_ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_aux_gnt(perf_aux_gnt)
`endif
  );

  dmem_arb_chk u_chk (
    .clk(clk), .rst(rst), .c_req(c_req), .c_gnt(c_gnt), .a_req(a_req), .a_gnt(a_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic aux, input logic [31:0] val);
    exp_t e;
    e.aux = aux;
    e.val = val;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every grant and every read response must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (c_gnt || a_gnt) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", {30'd0, a_gnt, c_gnt}, 32'd0);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_owner", {30'd0, a_gnt, c_gnt}, e.aux ? 32'd2 : 32'd1);
          check("gnt_addr", mem_addr, e.val);
        end
      end
      if (c_rvalid || a_rvalid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {30'd0, a_rvalid, c_rvalid}, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_owner", {30'd0, a_rvalid, c_rvalid}, e.aux ? 32'd2 : 32'd1);
          check("rsp_data", a_rvalid ? a_rdata : c_rdata, e.val);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_wdata = 32'd0; c_size = 3'd0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_size = 3'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hCAFE0000;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_gnt", {30'd0, a_gnt, c_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, a_rvalid, c_rvalid}, 32'd0);
    check("rst_stall", {31'd0, c_stall}, 32'd0);
    check("rst_err", {31'd0, err_unexp}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata_pass", c_rdata, 32'hCAFE0000);
    step();

    // T1: single core load, response two cycles after the grant
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0100; c_size = SZ_W; mem_gnt = 1'b1;
    gnt_q.push_back(mk(1'b0, 32'h0000_0100));
    rsp_q.push_back(mk(1'b0, 32'hDEADBEEF));
    @(negedge clk);
    check("t1_mem_size", {29'd0, mem_size}, {29'd0, SZ_W});
    check("t1_c_gnt", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;
    @(negedge clk);
    check("t1_stall_pending", {31'd0, c_stall}, 32'd1);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_c_rvalid", {31'd0, c_rvalid}, 32'd1);
    check("t1_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t1_stall_clear", {31'd0, c_stall}, 32'd0);
    step();

    // T2: both store continuously; aux wins on the 9th cycle
    c_we = 1'b1; c_addr = 32'h0000_0200; a_we = 1'b1; a_addr = 32'h0000_0300;
    for (int i = 0; i < 8; i++) gnt_q.push_back(mk(1'b0, 32'h0000_0200));
    gnt_q.push_back(mk(1'b1, 32'h0000_0300));
    gnt_q.push_back(mk(1'b0, 32'h0000_0200));
    for (int i = 0; i < 10; i++) begin
      c_req = 1'b1;
      a_req = (i <= 8);
      @(negedge clk);
      check("t2_a_gnt", {31'd0, a_gnt}, (i == 8) ? 32'd1 : 32'd0);
      step();
    end
    c_req = 1'b0; a_req = 1'b0;
    step();

    // T3: aux holds the port through three back-pressured cycles
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0400; mem_gnt = 1'b0;
    gnt_q.push_back(mk(1'b1, 32'h0000_0400));
    gnt_q.push_back(mk(1'b0, 32'h0000_0500));
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) begin
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h0000_0500;
      end
      @(negedge clk);
      check("t3_mem_addr", mem_addr, 32'h0000_0400);
      check("t3_a_gnt_wait", {31'd0, a_gnt}, 32'd0);
      step();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check("t3_a_gnt", {31'd0, a_gnt}, 32'd1);
    step();
    a_req = 1'b0;
    @(negedge clk);
    check("t3_c_gnt", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;

    // T4: two outstanding core loads block a third until a response frees a slot
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0600;
    gnt_q.push_back(mk(1'b0, 32'h0000_0600));
    gnt_q.push_back(mk(1'b0, 32'h0000_0604));
    gnt_q.push_back(mk(1'b0, 32'h0000_0608));
    rsp_q.push_back(mk(1'b0, 32'h0000_00A1));
    rsp_q.push_back(mk(1'b0, 32'h0000_00A2));
    rsp_q.push_back(mk(1'b0, 32'h0000_00A3));
    step();
    c_addr = 32'h0000_0604;
    step();
    c_addr = 32'h0000_0608;
    @(negedge clk);
    check("t4_full_mem_req", {31'd0, mem_req}, 32'd0);
    check("t4_full_stall", {31'd0, c_stall}, 32'd1);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A1;
    @(negedge clk);
    check("t4_pop_no_unblock", {31'd0, mem_req}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t4_gnt_after_pop", {31'd0, c_gnt}, 32'd1);
    step();
    c_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A2;
    step();
    mem_rdata = 32'h0000_00A3;
    step();
    mem_rvalid = 1'b0;
    step();

    // T5: core load then aux load; in-order responses steered to each owner
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0700;
    gnt_q.push_back(mk(1'b0, 32'h0000_0700));
    gnt_q.push_back(mk(1'b1, 32'h0000_0800));
    rsp_q.push_back(mk(1'b0, 32'h0000_0011));
    rsp_q.push_back(mk(1'b1, 32'h0000_0022));
    step();
    c_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_0800;
    step();
    a_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
    @(negedge clk);
    check("t5_c_rvalid", {31'd0, c_rvalid}, 32'd1);
    step();
    mem_rdata = 32'h0000_0022;
    @(negedge clk);
    check("t5_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    step();
    mem_rvalid = 1'b0;
    step();

    // T6: reset with a load outstanding; the late response is flagged
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0900;
    gnt_q.push_back(mk(1'b0, 32'h0000_0900));
    step();
    c_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_stall_after_rst", {31'd0, c_stall}, 32'd0);
    check("t6_err_after_rst", {31'd0, err_unexp}, 32'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033;
    @(negedge clk);
    check("t6_no_rvalid", {30'd0, a_rvalid, c_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t6_err_set", {31'd0, err_unexp}, 32'd1);
    step();
    step();
    @(negedge clk);
    check("t6_err_sticky", {31'd0, err_unexp}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", {31'd0, err_unexp}, 32'd0);
    step();

    // Every expected grant and response must have been observed
    check("gnt_q_left", 32'(gnt_q.size()), 32'd0);
    check("rsp_q_left", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
